// File: rtl/spi_sample_buffer.sv
// spi_sample_buffer: tags SPI sensor words with a channel index and stores whole
// frames in a first-word-fall-through FIFO. A frame is admitted only when the
// FIFO has room for all of it at frame start; otherwise the frame is dropped whole.
module spi_sample_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CH_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic              sync_err,
  output logic [7:0]        drop_count,
  input  logic              clear_flags
);

  localparam int unsigned     DEPTH     = 1 << ADDR_W;
  localparam int unsigned     ENTRY_W   = DATA_W + CH_W + 1;
  // Highest fill level that still leaves room for a complete frame.
  localparam logic [ADDR_W:0] ADMIT_MAX = (ADDR_W+1)'(DEPTH - NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ch_cnt;
  logic [CH_W-1:0]     w_ch_cnt_nxt;

  logic                w_has_room;
  logic                w_push;
  logic                w_pop;
  logic                w_wr_last;
  logic [CH_W-1:0]     w_wr_ch;
  logic                w_drop_evt;
  logic                w_sync_evt;
  logic [ENTRY_W-1:0]  w_wr_entry;

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W-1:0]   w_rd_ptr_nxt;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_nxt;
  logic [ADDR_W:0]     w_remain;
  logic [ENTRY_W-1:0]  r_head;
  logic                r_valid;

  logic                r_overflow;
  logic                r_sync_err;
  logic [7:0]          r_drop_count;

  // Admission uses the registered level; a pop in the same cycle is not credited.
  assign w_has_room = (r_count <= ADMIT_MAX);
  assign w_pop      = r_valid & out_ready;
  assign w_wr_entry = {w_wr_last, w_wr_ch, rx_data};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: frame_start restarts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (rx_valid) begin
      if (frame_start) begin
        w_state_nxt = w_has_room ? S_FILL : S_DROP;
      end else begin
        case (r_state)
          S_FILL, S_DROP: begin
            if (r_ch_cnt == LAST_CH) w_state_nxt = S_IDLE;
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Output logic: FIFO write, channel tagging and error events
  always_comb begin
    w_push       = 1'b0;
    w_wr_last    = 1'b0;
    w_wr_ch      = r_ch_cnt;
    w_drop_evt   = 1'b0;
    w_sync_evt   = 1'b0;
    w_ch_cnt_nxt = r_ch_cnt;
    if (rx_valid) begin
      if (frame_start) begin
        w_ch_cnt_nxt = CH_W'(1);
        w_wr_ch      = '0;
        if (w_has_room) begin
          w_push = 1'b1;
        end else begin
          w_drop_evt = 1'b1;
        end
      end else begin
        case (r_state)
          S_FILL, S_DROP: begin
            w_push       = (r_state == S_FILL);
            w_wr_last    = (r_ch_cnt == LAST_CH);
            w_ch_cnt_nxt = (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + CH_W'(1);
          end
          S_IDLE: begin
            w_sync_evt = 1'b1;
          end
          default: begin
            w_sync_evt = 1'b0;
          end
        endcase
      end
    end
  end

  // Channel counter and sticky status flags; clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_cnt     <= '0;
      r_overflow   <= 1'b0;
      r_sync_err   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_ch_cnt <= w_ch_cnt_nxt;
      if (clear_flags) begin
        r_overflow   <= 1'b0;
        r_sync_err   <= 1'b0;
        r_drop_count <= '0;
      end else begin
        if (w_drop_evt) begin
          r_overflow <= 1'b1;
          if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
        if (w_sync_evt) r_sync_err <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping: next read pointer, count and entries left after a pop
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + ADDR_W'(w_pop);
    w_remain     = r_count - (ADDR_W+1)'(w_pop);
    w_count_nxt  = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (ADDR_W+1)'(1);
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // Pointers, count and the fall-through head register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      // Nothing left behind the popped head: the incoming word becomes head directly.
      if (w_remain == '0) begin
        if (w_push) r_head <= w_wr_entry;
      end else begin
        r_head <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  assign out_data   = r_head[DATA_W-1:0];
  assign out_ch     = r_head[DATA_W +: CH_W];
  assign out_last   = r_head[ENTRY_W-1];
  assign out_valid  = r_valid;
  assign fill_level = r_count;
  assign overflow   = r_overflow;
  assign sync_err   = r_sync_err;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_spi_sample_buffer.sv
// Directed testbench for spi_sample_buffer (DATA_W=16, NUM_CH=4, ADDR_W=6, CH_W=4).
module tb_spi_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_start;
  logic [15:0] out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  fill_level;
  logic        overflow;
  logic        sync_err;
  logic [7:0]  drop_count;
  logic        clear_flags;

  int n_checks = 0;
  int n_errors = 0;

  spi_sample_buffer #(
    .DATA_W(16), .NUM_CH(4), .ADDR_W(6), .CH_W(4)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_start(frame_start), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .sync_err(sync_err),
    .drop_count(drop_count), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at negedge, away from the active edge.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic fs);
    rx_data     = d;
    frame_start = fs;
    rx_valid    = 1'b1;
    @(negedge clk);
    rx_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;
    idle(2);

    // 1: reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // 1: single frame with consumer always ready
    out_ready = 1'b1;
    chk("t1_pre_valid", 32'(out_valid), 32'd0);
    push(16'h1111, 1'b1);
    chk("t1_w0_valid", 32'(out_valid), 32'd1);
    chk("t1_w0_data", 32'(out_data), 32'h1111);
    chk("t1_w0_ch", 32'(out_ch), 32'd0);
    chk("t1_w0_last", 32'(out_last), 32'd0);
    push(16'h2222, 1'b0);
    chk("t1_w1_data", 32'(out_data), 32'h2222);
    chk("t1_w1_ch", 32'(out_ch), 32'd1);
    chk("t1_w1_last", 32'(out_last), 32'd0);
    chk("t1_w1_fill", 32'(fill_level), 32'd1);
    push(16'h3333, 1'b0);
    chk("t1_w2_data", 32'(out_data), 32'h3333);
    chk("t1_w2_ch", 32'(out_ch), 32'd2);
    chk("t1_w2_last", 32'(out_last), 32'd0);
    push(16'h4444, 1'b0);
    chk("t1_w3_data", 32'(out_data), 32'h4444);
    chk("t1_w3_ch", 32'(out_ch), 32'd3);
    chk("t1_w3_last", 32'(out_last), 32'd1);
    idle(1);
    chk("t1_empty_valid", 32'(out_valid), 32'd0);
    chk("t1_empty_fill", 32'(fill_level), 32'd0);
    chk("t1_hold_data", 32'(out_data), 32'h4444);

    // 2: fill to 64 with consumer stalled, then a 17th frame is dropped whole
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 4; c++)
        push(16'hA000 | 16'(i*4 + c), c == 0);
    chk("t2_full_fill", 32'(fill_level), 32'd64);
    chk("t2_head_data", 32'(out_data), 32'hA000);
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    for (int c = 0; c < 4; c++) push(16'hB000 | 16'(c), c == 0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_count), 32'd1);
    chk("t2_fill_kept", 32'(fill_level), 32'd64);
    chk("t2_sync", 32'(sync_err), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk("t2_drain_data", 32'(out_data), 32'(16'hA000 | 16'(k)));
      chk("t2_drain_ch", 32'(out_ch), 32'(k % 4));
      chk("t2_drain_last", 32'(out_last), 32'((k % 4) == 3));
      @(negedge clk);
    end
    chk("t2_drained_valid", 32'(out_valid), 32'd0);
    chk("t2_drained_fill", 32'(fill_level), 32'd0);

    // 3: 61 stored (free 3) rejects a frame; after one pop the frame fits exactly
    out_ready = 1'b0;
    for (int k = 0; k < 60; k++) push(16'hC000 | 16'(k), (k % 4) == 0);
    push(16'hC03C, 1'b1);
    chk("t3_fill61", 32'(fill_level), 32'd61);
    push(16'hD000, 1'b1);
    chk("t3_rej_fill", 32'(fill_level), 32'd61);
    chk("t3_rej_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("t3_pop_fill", 32'(fill_level), 32'd60);
    for (int c = 0; c < 4; c++) push(16'hE000 | 16'(c), c == 0);
    chk("t3_acc_fill", 32'(fill_level), 32'd64);
    chk("t3_acc_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 0) chk("t3_head", 32'(out_data), 32'hC001);
      if (k == 59) begin
        chk("t3_part_data", 32'(out_data), 32'hC03C);
        chk("t3_part_last", 32'(out_last), 32'd0);
      end
      if (k >= 60) begin
        chk("t3_new_data", 32'(out_data), 32'(16'hE000 | 16'(k - 60)));
        chk("t3_new_ch", 32'(out_ch), 32'(k - 60));
        chk("t3_new_last", 32'(out_last), 32'(k == 63));
      end
      @(negedge clk);
    end
    chk("t3_drained_fill", 32'(fill_level), 32'd0);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    chk("t3_clr_drop", 32'(drop_count), 32'd0);

    // 4: words outside a frame raise sync_err and are not stored
    push(16'h5A5A, 1'b0);
    chk("t4_sync", 32'(sync_err), 32'd1);
    chk("t4_fill", 32'(fill_level), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    chk("t4_sync_clr", 32'(sync_err), 32'd0);
    clear_flags = 1'b1;
    push(16'h5A5B, 1'b0);
    clear_flags = 1'b0;
    chk("t4_clr_prio", 32'(sync_err), 32'd0);

    // 5: abandoned partial frame stays; new frame restarts tags at 0
    out_ready = 1'b0;
    push(16'h5000, 1'b1);
    push(16'h5001, 1'b0);
    for (int c = 0; c < 4; c++) push(16'h6000 | 16'(c), c == 0);
    chk("t5_fill", 32'(fill_level), 32'd6);
    out_ready = 1'b1;
    chk("t5_d0", 32'(out_data), 32'h5000);
    chk("t5_c0", 32'(out_ch), 32'd0);
    idle(1);
    chk("t5_d1", 32'(out_data), 32'h5001);
    chk("t5_c1", 32'(out_ch), 32'd1);
    chk("t5_l1", 32'(out_last), 32'd0);
    idle(1);
    for (int c = 0; c < 4; c++) begin
      chk("t5_new_data", 32'(out_data), 32'(16'h6000 | 16'(c)));
      chk("t5_new_ch", 32'(out_ch), 32'(c));
      chk("t5_new_last", 32'(out_last), 32'(c == 3));
      @(negedge clk);
    end
    chk("t5_empty", 32'(fill_level), 32'd0);
    // continuous push+pop at level 1
    out_ready = 1'b0;
    push(16'h7000, 1'b1);
    chk("t5_lvl1", 32'(fill_level), 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      push(16'h7000 | 16'(k), (k % 4) == 0);
      chk("t5_pp_fill", 32'(fill_level), 32'd1);
      chk("t5_pp_data", 32'(out_data), 32'(16'h7000 | 16'(k)));
      chk("t5_pp_ch", 32'(out_ch), 32'(k % 4));
    end
    idle(1);
    chk("t5_pp_drain", 32'(fill_level), 32'd0);
    chk("t5_pp_sync", 32'(sync_err), 32'd0);

    // 6: reset in the middle of a frame with 10 entries stored
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) push(16'h9000 | 16'(k), (k % 4) == 0);
    chk("t6_fill10", 32'(fill_level), 32'd10);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_fill", 32'(fill_level), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'd0);
    push(16'h900A, 1'b0);
    chk("t6_sync", 32'(sync_err), 32'd1);
    chk("t6_fill", 32'(fill_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
